fifo_1r1w_large_rr_enq_arbiter: RTL and testbench

- Shares the enqueue port of one bsg_fifo_1r1w_large among num_req_p requesters.
- Each cycle it grants one requester in round-robin order.
- Each written word is tagged with the requester ID.
- Per-requester occupancy counters track that requester's words held in the FIFO; a requester at quota is masked from arbitration.
- The consumer reports each dequeue's ID back to the block, so one requester cannot monopolise the FIFO.

---
 rtl/fifo_rr_arb_pkg.sv | 21 ++
 rtl/fifo_rr_arb_prio_pick.sv | 28 ++
 rtl/fifo_1r1w_large_rr_enq_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_1r1w_large_rr_enq_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arb_pkg.sv
// Shared widths, error causes and stats width for the round-robin FIFO enqueue arbiter.
package fifo_rr_arb_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNDERFLOW,
    ERR_BAD_ID
  } err_cause_e;

  // A single requester still carries a 1-bit (constant 0) id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int q);
    return $clog2(q + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_arb_prio_pick.sv
// Rotating-priority encoder: first set bit of elig_i at or above ptr_i, wrapping around.
module fifo_rr_arb_prio_pick
  import fifo_rr_arb_pkg::*;
#(
  parameter  int num_req_p   = 4,
  localparam int id_width_lp = id_width(num_req_p)
) (
  input  logic [num_req_p-1:0]   elig_i,
  input  logic [id_width_lp-1:0] ptr_i,
  output logic                   grant_v_o,
  output logic [id_width_lp-1:0] grant_id_o
);

  logic [2*num_req_p-1:0] rot;

  always_comb begin
    rot        = {elig_i, elig_i} >> ptr_i;
    grant_v_o  = 1'b0;
    grant_id_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!grant_v_o && rot[i]) begin
        grant_v_o  = 1'b1;
        grant_id_o = id_width_lp'((int'(ptr_i) + i) % num_req_p);
      end
    end
  end

endmodule

// File: rtl/fifo_1r1w_large_rr_enq_arbiter.sv
// Round-robin enqueue arbiter with per-requester FIFO quotas and ID tagging.
// Optional per-requester stall counters when FIFO_RR_ARB_STATS_EN is defined.
module fifo_1r1w_large_rr_enq_arbiter
  import fifo_rr_arb_pkg::*;
#(
  parameter  int num_req_p    = 4,
  parameter  int width_p      = 8,
  parameter  int els_p        = 64,
  parameter  int quota_p      = 16,
  localparam int id_width_lp  = id_width(num_req_p),
  localparam int cnt_width_lp = cnt_width((quota_p < els_p) ? quota_p : els_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              v_i,
  output logic [num_req_p-1:0]              ready_o,
  input  logic [num_req_p*width_p-1:0]      data_i,
  output logic                              fifo_v_o,
  output logic [id_width_lp+width_p-1:0]    fifo_data_o,
  input  logic                              fifo_ready_i,
  input  logic                              deq_v_i,
  input  logic [id_width_lp-1:0]            deq_id_i,
  output logic [num_req_p*cnt_width_lp-1:0] occ_o,
`ifdef FIFO_RR_ARB_STATS_EN
  output logic [num_req_p*STAT_W-1:0]       stall_cnt_o,
`endif
  output logic                              err_o
);

  logic [num_req_p-1:0]   elig;
  logic [num_req_p-1:0]   underflow;
  logic [width_p-1:0]     data_arr [num_req_p];
  logic                   grant_v;
  logic [id_width_lp-1:0] grant_id;
  logic [id_width_lp-1:0] ptr_q, ptr_d;
  logic                   fire;
  logic                   bad_id;
  logic                   err_q, err_d;
  err_cause_e             err_cause;

  fifo_rr_arb_prio_pick #(.num_req_p(num_req_p)) u_pick (
    .elig_i     (elig),
    .ptr_i      (ptr_q),
    .grant_v_o  (grant_v),
    .grant_id_o (grant_id)
  );

  assign fire        = grant_v && fifo_ready_i;
  assign fifo_v_o    = reset_n_i && grant_v;
  assign fifo_data_o = {grant_id, data_arr[grant_id]};
  // One extra bit keeps the range check meaningful when num_req_p is a power of two.
  assign bad_id      = {1'b0, deq_id_i} >= (id_width_lp+1)'(num_req_p);

  always_comb begin
    ready_o = '0;
    if (reset_n_i && grant_v && fifo_ready_i)
      ready_o[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire)
      ptr_d = (grant_id == id_width_lp'(num_req_p-1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    err_cause = ERR_NONE;
    if (deq_v_i) begin
      if (bad_id)          err_cause = ERR_BAD_ID;
      else if (|underflow) err_cause = ERR_UNDERFLOW;
    end
    err_d = err_q || (err_cause != ERR_NONE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  genvar gi;
  for (gi = 0; gi < num_req_p; gi++) begin : g_req
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    inc, dec, deq_hit;

    assign data_arr[gi]   = data_i[gi*width_p +: width_p];
    assign elig[gi]       = v_i[gi] && (cnt_q < cnt_width_lp'(quota_p));
    assign deq_hit        = deq_v_i && !bad_id && (deq_id_i == id_width_lp'(gi));
    assign underflow[gi]  = deq_hit && (cnt_q == '0);
    assign inc            = fire && (grant_id == id_width_lp'(gi));
    assign dec            = deq_hit && (cnt_q != '0);

    // A same-cycle enqueue and dequeue on one requester cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + 1'b1;
      else if (dec && !inc) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
    end

    assign occ_o[gi*cnt_width_lp +: cnt_width_lp] = cnt_q;

`ifdef FIFO_RR_ARB_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (v_i[gi] && !ready_o[gi] && (stall_q != {STAT_W{1'b1}}))
        stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) stall_q <= '0;
      else            stall_q <= stall_d;
    end

    assign stall_cnt_o[gi*STAT_W +: STAT_W] = stall_q;
`endif
  end

endmodule

// File: tb/tb_fifo_1r1w_large_rr_enq_arbiter.sv
// Scoreboard bench for the round-robin enqueue arbiter (4 requesters, quota 2).
module tb_fifo_1r1w_large_rr_enq_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  v_i;
  logic [3:0]  ready_o;
  logic [31:0] data_i;
  logic        fifo_v_o;
  logic [9:0]  fifo_data_o;
  logic        fifo_ready_i;
  logic        deq_v_i;
  logic [1:0]  deq_id_i;
  logic [7:0]  occ_o;
  logic        err_o;
`ifdef FIFO_RR_ARB_STATS_EN
  logic [63:0] stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  fifo_1r1w_large_rr_enq_arbiter #(
    .num_req_p(4), .width_p(8), .els_p(64), .quota_p(2)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .fifo_v_o     (fifo_v_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_ready_i (fifo_ready_i),
    .deq_v_i      (deq_v_i),
    .deq_id_i     (deq_id_i),
    .occ_o        (occ_o),
`ifdef FIFO_RR_ARB_STATS_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .err_o        (err_o)
  );

  typedef struct {
    bit         fv;
    logic [9:0] fdata;
    logic [3:0] ready;
  } out_t;

  typedef struct {
    logic [7:0] occ;
    bit         err;
  } st_t;

  out_t out_q[$];
  st_t  st_q[$];

  int checks = 0;
  int errors = 0;

  int m_ptr;
  int m_cnt[4];
  bit m_err;
  int m_stall[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_err = 0;
    for (int k = 0; k < 4; k++) begin
      m_cnt[k]   = 0;
      m_stall[k] = 0;
    end
  endtask

  // One cycle: drive, predict, compare combinational outputs, then registered state.
  task automatic step(input logic [3:0] vv, input logic [31:0] dd, input logic rr,
                      input logic dq, input logic [1:0] id, output int gid);
    out_t eo;
    st_t  es;
    int   g;
    bit   fire, decok;
    @(negedge clk_i);
    v_i = vv; data_i = dd; fifo_ready_i = rr; deq_v_i = dq; deq_id_i = id;

    g = -1;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (m_ptr + i) % 4;
      if (g < 0 && vv[idx] && m_cnt[idx] < 2) g = idx;
    end
    eo.fv    = (g >= 0);
    eo.ready = (g >= 0 && rr) ? 4'(1 << g) : 4'b0;
    eo.fdata = (g >= 0) ? {2'(g), dd[g*8 +: 8]} : 10'b0;
    out_q.push_back(eo);

    for (int k = 0; k < 4; k++)
      if (vv[k] && !eo.ready[k] && m_stall[k] < 65535) m_stall[k]++;
    fire  = (g >= 0) && rr;
    decok = dq && (m_cnt[id] > 0);
    if (dq && m_cnt[id] == 0) m_err = 1;
    if (fire) begin
      m_cnt[g]++;
      m_ptr = (g + 1) % 4;
    end
    if (decok) m_cnt[id]--;
    es.occ = {2'(m_cnt[3]), 2'(m_cnt[2]), 2'(m_cnt[1]), 2'(m_cnt[0])};
    es.err = m_err;
    st_q.push_back(es);

    #1;
    eo = out_q.pop_front();
    check("fifo_v", fifo_v_o, eo.fv);
    if (eo.fv) check("fifo_data", fifo_data_o, eo.fdata);
    check("ready", ready_o, eo.ready);
    gid = fifo_v_o ? int'(fifo_data_o[9:8]) : -1;

    @(posedge clk_i);
    #1;
    es = st_q.pop_front();
    check("occ", occ_o, es.occ);
    check("err", err_o, es.err);
`ifdef FIFO_RR_ARB_STATS_EN
    check("stall", stall_cnt_o, {16'(m_stall[3]), 16'(m_stall[2]), 16'(m_stall[1]), 16'(m_stall[0])});
`endif
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    v_i = 4'hF; fifo_ready_i = 1'b1; deq_v_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 4'b0);
    check("rst_fifo_v", fifo_v_o, 1'b0);
    check("rst_occ", occ_o, 8'h0);
    check("rst_err", err_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    v_i = 4'h0;
  endtask

  initial begin
    int gid;
    reset_n_i = 1'b0; v_i = '0; data_i = '0; fifo_ready_i = 1'b1;
    deq_v_i = 1'b0; deq_id_i = '0;
    model_reset();
    do_reset();

    // Reset state and first grant
    step(4'hF, 32'h44332211, 1'b1, 1'b0, 2'd0, gid);
    check("t1_gid", gid, 0);

    // Round-robin until every requester sits at quota
    for (int i = 1; i < 8; i++) begin
      step(4'hF, $urandom, 1'b1, 1'b0, 2'd0, gid);
      check("t2_gid", gid, i % 4);
    end
    step(4'hF, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t2_blocked", gid, -1);
    check("t2_occ", occ_o, 8'hAA);

    // FIFO full holds the pointer
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0110, $urandom, 1'b0, 1'b0, 2'd0, gid);
    check("t3_occ_hold", occ_o, 8'h00);
    step(4'b0110, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t3_gid", gid, 1);

    // Same-id accounting on requester 2
    step(4'b0100, $urandom, 1'b1, 1'b0, 2'd0, gid);
    step(4'b0100, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t4_at_quota", occ_o[5:4], 2'd2);
    step(4'b0100, $urandom, 1'b1, 1'b1, 2'd2, gid);
    check("t4_masked", gid, -1);
    check("t4_dec", occ_o[5:4], 2'd1);
    step(4'b0100, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t4_regrant", gid, 2);
    step(4'b0000, $urandom, 1'b1, 1'b1, 2'd2, gid);
    step(4'b0100, $urandom, 1'b1, 1'b1, 2'd2, gid);
    check("t4_same_gid", gid, 2);
    check("t4_same_cnt", occ_o[5:4], 2'd1);

    // Underflow is sticky until reset
    step(4'b0000, $urandom, 1'b1, 1'b1, 2'd3, gid);
    check("t5_err", err_o, 1'b1);
    step(4'b0001, $urandom, 1'b1, 1'b0, 2'd0, gid);
    step(4'b0000, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t5_sticky", err_o, 1'b1);
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("t5_rst_err", err_o, 1'b0);
    check("t5_rst_occ", occ_o, 8'h00);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(4'hF, $urandom, 1'b1, 1'b0, 2'd0, gid);
    check("t5_post_gid", gid, 0);

`ifdef FIFO_RR_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0010, $urandom, 1'b0, 1'b0, 2'd0, gid);
    check("t6_stall5", stall_cnt_o[31:16], 16'd5);
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk_i);
      v_i = 4'b0010; fifo_ready_i = 1'b0; deq_v_i = 1'b0;
    end
    @(posedge clk_i);
    #1;
    check("t6_sat", stall_cnt_o[31:16], 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
